// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI sequencer/arbiter.
package qspi_pkg;

  typedef enum logic [2:0] {
    INIT_LO,
    INIT_HI,
    IDLE,
    ISSUE,
    BUSY,
    DONE
  } qarb_state_t;

  localparam logic [1:0] QSPI_CS_IDLE = 2'b11;

  // Line-offset bit count for a cache line of len bytes.
  function automatic int line_lw(input int len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/qspi_arb_rr_arb2.sv
// Two-way round-robin arbiter; the last pointer records which side won most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_dc,
  output logic [1:0] gnt
);

  // last = 0: icache (bit 0) won last, so dcache (bit 1) is favoured on contention.
  logic last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b0;
    end else if (update) begin
      last <= upd_dc;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// Sequencer/arbiter sharing the QSPI engine between icache, dcache and config writes.
//  state   | meaning
//  INIT_LO | wait for engine quad-enable to start (cs active)
//  INIT_HI | wait for engine quad-enable to finish (cs idle)
//  IDLE    | sample cfg/ic/dc requests while cs idle
//  ISSUE   | q_req held until engine asserts cs
//  BUSY    | transaction in flight, wait for cs idle
//  DONE    | ack presented to the winning requester
module qspi_arb
  import qspi_pkg::*;
#(
  parameter  int PA          = 24,
  parameter  int LINE_LENGTH = 4,
  parameter  int TIMEOUT     = 255,
  localparam int LW          = line_lw(LINE_LENGTH),
  localparam int TW          = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_req,
  input  logic             ic_mem,
  input  logic [PA-1:LW]   ic_paddr,
  output logic             ic_ack,
  input  logic             dc_req,
  input  logic             dc_mem,
  input  logic             dc_write,
  input  logic [PA-1:LW]   dc_paddr,
  output logic             dc_ack,
  input  logic             cfg_req,
  input  logic [3:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ack,
  output logic             q_req,
  output logic             q_i_d,
  output logic             q_mem,
  output logic             q_write,
  output logic [PA-1:LW]   q_paddr,
  input  logic [1:0]       q_cs,
  output logic [3:0]       q_reg_addr,
  output logic [7:0]       q_reg_data,
  output logic             q_reg_write,
  output logic             busy,
  output logic             timeout_err
);

  qarb_state_t   state;
  logic [TW-1:0] tmr;
  logic          cs_idle;
  logic          tmo;
  logic [1:0]    gnt;
  logic          win_dc;
  logic          any_gnt;
  logic          arb_upd;

  assign cs_idle = (q_cs == QSPI_CS_IDLE);
  assign tmo     = (tmr == TW'(TIMEOUT - 1));
  assign win_dc  = gnt[1];
  assign any_gnt = |gnt;

  // A timed-out transaction still completes from the requester's view, so it moves the pointer too.
  assign arb_upd = (state == DONE)
                 | ((state == ISSUE) &  cs_idle & tmo)
                 | ((state == BUSY)  & ~cs_idle & tmo);

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({dc_req, ic_req}),
    .update (arb_upd),
    .upd_dc (~q_i_d),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT_LO;
      tmr         <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      cfg_ack     <= 1'b0;
      q_req       <= 1'b0;
      q_i_d       <= 1'b0;
      q_mem       <= 1'b0;
      q_write     <= 1'b0;
      q_paddr     <= '0;
      q_reg_addr  <= '0;
      q_reg_data  <= '0;
      q_reg_write <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      cfg_ack     <= 1'b0;
      q_reg_write <= 1'b0;
      tmr         <= tmr + 1'b1;
      case (state)
        INIT_LO: begin
          if (!cs_idle) begin
            state <= INIT_HI;
            tmr   <= '0;
          end else if (tmo) begin
            state       <= IDLE;
            tmr         <= '0;
            timeout_err <= 1'b1;
          end
        end
        INIT_HI: begin
          if (cs_idle) begin
            state <= IDLE;
            tmr   <= '0;
          end else if (tmo) begin
            state       <= IDLE;
            tmr         <= '0;
            timeout_err <= 1'b1;
          end
        end
        IDLE: begin
          tmr <= '0;
          if (cs_idle) begin
            if (cfg_req) begin
              q_reg_write <= 1'b1;
              q_reg_addr  <= cfg_addr;
              q_reg_data  <= cfg_data;
              cfg_ack     <= 1'b1;
            end else if (any_gnt) begin
              q_req   <= 1'b1;
              q_i_d   <= ~win_dc;
              q_mem   <= win_dc ? dc_mem : ic_mem;
              q_write <= win_dc & dc_write;
              q_paddr <= win_dc ? dc_paddr : ic_paddr;
              busy    <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!cs_idle) begin
            q_req <= 1'b0;
            state <= BUSY;
            tmr   <= '0;
          end else if (tmo) begin
            q_req       <= 1'b0;
            timeout_err <= 1'b1;
            ic_ack      <= q_i_d;
            dc_ack      <= ~q_i_d;
            busy        <= 1'b0;
            state       <= IDLE;
            tmr         <= '0;
          end
        end
        BUSY: begin
          if (cs_idle) begin
            ic_ack <= q_i_d;
            dc_ack <= ~q_i_d;
            state  <= DONE;
            tmr    <= '0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            ic_ack      <= q_i_d;
            dc_ack      <= ~q_i_d;
            busy        <= 1'b0;
            state       <= IDLE;
            tmr         <= '0;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          tmr   <= '0;
        end
        default: begin
          state <= INIT_LO;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb: init handshake, grants, round-robin, cfg deferral, timeout, reset.
module tb_qspi_arb;
  import qspi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, ic_mem, dc_req, dc_mem, dc_write, cfg_req;
  logic [21:0] ic_paddr, dc_paddr, q_paddr;
  logic [3:0]  cfg_addr, q_reg_addr;
  logic [7:0]  cfg_data, q_reg_data;
  logic [1:0]  q_cs;
  logic        ic_ack, dc_ack, cfg_ack, q_req, q_i_d, q_mem, q_write;
  logic        q_reg_write, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qspi_arb dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_mem(ic_mem), .ic_paddr(ic_paddr), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_mem(dc_mem), .dc_write(dc_write), .dc_paddr(dc_paddr), .dc_ack(dc_ack),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .q_req(q_req), .q_i_d(q_i_d), .q_mem(q_mem), .q_write(q_write), .q_paddr(q_paddr),
    .q_cs(q_cs), .q_reg_addr(q_reg_addr), .q_reg_data(q_reg_data), .q_reg_write(q_reg_write),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset, then run the engine's quad-enable handshake (cs low 10 cycles).
  task automatic do_init();
    reset = 1'b1;
    q_cs  = 2'b11;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q_cs  = 2'b10;
    repeat (10) @(negedge clk);
    q_cs = 2'b11;
    @(negedge clk);
  endtask

  task automatic wait_qreq(input string tag);
    int n = 0;
    while (q_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_qreq_seen"}, 32'(q_req), 32'h1);
  endtask

  // One complete engine transaction with field and ack checks.
  task automatic serve(input string tag, input logic exp_id, input logic [21:0] exp_paddr,
                       input logic exp_mem, input logic exp_write, input logic drop);
    wait_qreq(tag);
    chk({tag, "_i_d"},   32'(q_i_d),   32'(exp_id));
    chk({tag, "_paddr"}, 32'(q_paddr), 32'(exp_paddr));
    chk({tag, "_mem"},   32'(q_mem),   32'(exp_mem));
    chk({tag, "_write"}, 32'(q_write), 32'(exp_write));
    chk({tag, "_busy"},  32'(busy),    32'h1);
    q_cs = 2'b10;
    @(negedge clk);
    chk({tag, "_qreq_drop"}, 32'(q_req), 32'h0);
    repeat (2) @(negedge clk);
    chk({tag, "_paddr_hold"}, 32'(q_paddr), 32'(exp_paddr));
    q_cs = 2'b11;
    @(negedge clk);
    chk({tag, "_ack"}, 32'({ic_ack, dc_ack}), exp_id ? 32'h2 : 32'h1);
    if (drop) begin
      if (exp_id) ic_req = 1'b0;
      else        dc_req = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_ack_end"}, 32'({ic_ack, dc_ack}), 32'h0);
  endtask

  initial begin
    reset = 1'b1; q_cs = 2'b11;
    ic_req = 0; ic_mem = 0; ic_paddr = '0;
    dc_req = 0; dc_mem = 0; dc_write = 0; dc_paddr = '0;
    cfg_req = 0; cfg_addr = '0; cfg_data = '0;

    // Reset values
    #1;
    chk("rst_qreq", 32'(q_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(INIT_LO));

    do_init();
    chk("init_state", 32'(dut.state), 32'(IDLE));
    chk("init_err", 32'(timeout_err), 32'h0);

    // Single icache fill
    ic_req = 1; ic_mem = 0; ic_paddr = 22'h12345;
    serve("ic1", 1'b1, 22'h12345, 1'b0, 1'b0, 1'b1);
    chk("ic1_idle_busy", 32'(busy), 32'h0);

    // cfg raised during a dcache fill is deferred until after dc_ack
    dc_req = 1; dc_mem = 1; dc_write = 0; dc_paddr = 22'h2ABCD;
    wait_qreq("cfg_dc");
    chk("cfg_dc_i_d", 32'(q_i_d), 32'h0);
    chk("cfg_dc_mem", 32'(q_mem), 32'h1);
    q_cs = 2'b10;
    @(negedge clk);
    cfg_req = 1; cfg_addr = 4'h1; cfg_data = 8'h83;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cfg_held_off", 32'(q_reg_write), 32'h0);
    end
    q_cs = 2'b11;
    @(negedge clk);
    chk("cfg_dc_ack", 32'(dc_ack), 32'h1);
    chk("cfg_wr_before_ack", 32'(q_reg_write), 32'h0);
    dc_req = 0;
    @(negedge clk);
    chk("cfg_wr_gap", 32'(q_reg_write), 32'h0);
    @(negedge clk);
    chk("cfg_wr", 32'(q_reg_write), 32'h1);
    chk("cfg_ack", 32'(cfg_ack), 32'h1);
    chk("cfg_addr", 32'(q_reg_addr), 32'h1);
    chk("cfg_data", 32'(q_reg_data), 32'h83);
    cfg_req = 0;
    @(negedge clk);
    chk("cfg_wr_end", 32'(q_reg_write), 32'h0);

    // Engine never responds: ISSUE times out after 255 cycles
    ic_req = 1; ic_paddr = 22'h00777;
    wait_qreq("tmo");
    repeat (254) @(negedge clk);
    chk("tmo_before_qreq", 32'(q_req), 32'h1);
    chk("tmo_before_err", 32'(timeout_err), 32'h0);
    @(negedge clk);
    chk("tmo_qreq", 32'(q_req), 32'h0);
    chk("tmo_err", 32'(timeout_err), 32'h1);
    chk("tmo_ack", 32'(ic_ack), 32'h1);
    ic_req = 0;
    @(negedge clk);
    chk("tmo_ack_end", 32'(ic_ack), 32'h0);
    chk("tmo_err_sticky", 32'(timeout_err), 32'h1);

    // Reset while BUSY
    dc_req = 1; dc_write = 1; dc_paddr = 22'h01111;
    wait_qreq("rb");
    q_cs = 2'b10;
    @(negedge clk);
    chk("rb_in_busy", 32'(dut.state), 32'(BUSY));
    #2 reset = 1'b1;
    #1;
    chk("rb_qreq", 32'(q_req), 32'h0);
    chk("rb_busy", 32'(busy), 32'h0);
    chk("rb_acks", 32'({ic_ack, dc_ack, cfg_ack}), 32'h0);
    chk("rb_paddr", 32'(q_paddr), 32'h0);
    chk("rb_err", 32'(timeout_err), 32'h0);
    chk("rb_state", 32'(dut.state), 32'(INIT_LO));
    dc_req = 0;

    // Both held from reset: dc, ic, dc, ic
    ic_req = 1; ic_mem = 0; ic_paddr = 22'h00AAA;
    dc_req = 1; dc_mem = 1; dc_write = 1; dc_paddr = 22'h00555;
    do_init();
    serve("rr1", 1'b0, 22'h00555, 1'b1, 1'b1, 1'b0);
    serve("rr2", 1'b1, 22'h00AAA, 1'b0, 1'b0, 1'b0);
    serve("rr3", 1'b0, 22'h00555, 1'b1, 1'b1, 1'b0);
    serve("rr4", 1'b1, 22'h00AAA, 1'b0, 1'b0, 1'b0);
    ic_req = 0; dc_req = 0;
    repeat (3) @(negedge clk);
    chk("end_idle", 32'(dut.state), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_arb.md
# qspi_arb

Sequencer and arbiter in front of the `qspi` engine. It shares the single QSPI port between the instruction-cache fill path, the data-cache fill/writeback path and the configuration-register write path. It holds off all traffic until the engine's post-reset quad-enable sequence has finished. Each transaction is started with a request level, tracked through the engine's chip-select activity, and completed with a one-cycle ack to the winning requester.

## Interface
Parameters:
- `PA`, 24, physical address width
- `LINE_LENGTH`, 4, cache line length in bytes; `LW = $clog2(LINE_LENGTH)`
- `TIMEOUT`, 255, maximum number of cycles for any wait state; counter width is `$clog2(TIMEOUT+1)`

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `ic_req`  in  1  icache line-fill request (level)
- `ic_mem`  in  1  icache target device select
- `ic_paddr`  in  PA-LW  icache line address [PA-1:LW]
- `ic_ack`  out  1  one-cycle completion pulse to icache
- `dc_req`  in  1  dcache request (level)
- `dc_mem`  in  1  dcache target device select
- `dc_write`  in  1  1 = writeback, 0 = fill
- `dc_paddr`  in  PA-LW  dcache line address
- `dc_ack`  out  1  one-cycle completion pulse to dcache
- `cfg_req`  in  1  config register write request (level)
- `cfg_addr`  in  4  config register address
- `cfg_data`  in  8  config register data
- `cfg_ack`  out  1  one-cycle completion pulse to config path
- `q_req`  out  1  engine request
- `q_i_d`  out  1  1 = instruction fill
- `q_mem`  out  1  device select to engine
- `q_write`  out  1  write transaction
- `q_paddr`  out  PA-LW  line address to engine
- `q_cs`  in  2  engine chip selects, active-low; 2'b11 means idle
- `q_reg_addr`  out  4  engine register address
- `q_reg_data`  out  8  engine register data
- `q_reg_write`  out  1  engine register write strobe
- `busy`  out  1  a transaction is outstanding
- `timeout_err`  out  1  sticky error flag; cleared only by `reset`

## Operation
- States: INIT_LO, INIT_HI, IDLE, ISSUE, BUSY, DONE.
- INIT_LO: wait for `q_cs != 2'b11` (engine quad-enable in progress), then go to INIT_HI. INIT_HI: wait for `q_cs == 2'b11`, then go to IDLE. Either wait expiring after TIMEOUT cycles goes to IDLE and sets `timeout_err`.
- IDLE: requests are sampled only here, and only when `q_cs == 2'b11`. Priority:
  - `cfg_req` first. It pulses `q_reg_write` with `q_reg_addr`/`q_reg_data` and pulses `cfg_ack` in the same registered cycle, then stays in IDLE.
  - Otherwise `ic_req`/`dc_req` go through round-robin. The 1-bit `last` pointer favours the requester that was not granted last; its reset value is 0, meaning icache won last.
- On an ic/dc grant, the winner's mem, write (0 for icache), paddr and i_d are latched into the `q_*` registers, `q_req` is set to 1, and the FSM goes to ISSUE.
- ISSUE: `q_req` stays held until `q_cs != 2'b11`, then `q_req` drops and the FSM goes to BUSY. `q_*` address and control stay stable through BUSY.
- BUSY: wait for `q_cs == 2'b11`, then go to DONE.
- DONE: pulse `ic_ack` or `dc_ack` per the latched i_d, update `last`, go to IDLE.
- ISSUE and BUSY each time out after TIMEOUT cycles. On timeout: drop `q_req`, set `timeout_err`, still ack the requester, go to IDLE.
- `busy` = 1 in ISSUE, BUSY and DONE.
- Data strobes and write nibbles connect directly between the caches and the engine; this block does not touch them.

## Timing
- All outputs are registered.
- Reset values: state INIT_LO; all `q_*` outputs 0; all acks 0; `busy` 0; `timeout_err` 0.
- A request seen in IDLE at edge t gives `q_req` = 1 after t+1.
- An ack is issued one cycle after `q_cs` returns to 2'b11.
- A requester must drop its req in the cycle after its ack. A req still high in IDLE is treated as a new transaction.
- A cfg write completes with 1-cycle latency (`cfg_ack` and `q_reg_write` both appear after the sampling edge).
- Simultaneous `ic_req` and `dc_req`: one is granted per round-robin; the other waits at least until the next IDLE.
- `cfg_req` arriving during BUSY is deferred until IDLE, and then beats any pending ic/dc request.
- Asserting `reset` mid-transaction immediately returns all outputs to reset values. Whatever ack was pending is lost.
- The timeout counter clears on every state change.

## Structure
- Shared package `qspi_pkg` holds:
  - the state enum `qarb_state_t`;
  - the constant `QSPI_CS_IDLE = 2'b11`;
  - the `LW` function.
- Natural sub-module: `rr_arb2`, a 2-way round-robin arbiter with a `last` pointer and an update-enable input.

## Test plan
- Reset, then engine drives `q_cs=2'b10` for 10 cycles then 2'b11 → block enters IDLE, `timeout_err`=0.
- `ic_req`=1, `ic_paddr`=0x12345, `ic_mem`=0 → `q_req`=1, `q_i_d`=1, `q_paddr`=0x12345. `q_req` drops when `cs`=2'b10. `ic_ack` pulses one cycle after `cs` returns to 2'b11.
- `ic_req` and `dc_req` (write=1) both held from reset → grants go dc, ic, dc, ic with a matching ack for each.
- `cfg_req` addr=1 data=0x83 raised during a busy dcache fill → `q_reg_write` fires only after `dc_ack`, with addr=1 and data=0x83.
- Engine never lowers `q_cs` after `q_req` → after TIMEOUT cycles, `q_req`=0, `timeout_err`=1, and the requester receives its ack.
- `reset` asserted in BUSY → `q_req`, `busy` and the acks go to 0 asynchronously, and the state returns to INIT_LO.
